mem_responder: RTL and testbench

//   Memory-side responder for the shared request bus driven by the memory arbiter (PADDR/HWRITE/PDATA).

---
 rtl/mem_responder.sv | 133 +++++++++++++
 tb/tb_mem_responder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder on the shared request bus.
// Takes one request at a time, waits WAIT_STATES cycles, then completes it
// with a one-cycle HREADY pulse carrying read data or an error flag.
// All outputs are registered; the 64-bit word array is never reset.
module mem_responder #(
    parameter int          DEPTH       = 1024,
    parameter int          WAIT_STATES = 2,
    parameter logic [63:0] BASE_ADDR   = 64'h0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HTRANS,
    input  logic [63:0] PADDR,
    input  logic        HWRITE,
    input  logic [63:0] PDATA,
    output logic [63:0] HRDATA,
    output logic        HREADY,
    output logic        HRESP
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [7:0]  WS_LOAD = 8'(WAIT_STATES);
    localparam logic [63:0] DEPTH_W = 64'(DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]    state;
    logic [7:0]    cnt;
    logic [AW-1:0] idx_q;
    logic          write_q;
    logic          err_q;
    logic [63:0]   data_q;

    logic [63:0]   mem [DEPTH];

    logic [63:0]   offset;
    logic          addr_err;
    logic [AW-1:0] addr_idx;

    logic [AW-1:0] req_idx;
    logic          req_write;
    logic          req_err;
    logic [63:0]   req_data;
    logic          enter_resp;

    // Decode the live bus address: word index and error (misaligned, below base, past the end).
    always_comb begin
        // NOTE: every always_comb output gets a value on every path (here
        // unconditionally); a path that skips one would infer a latch.
        offset   = PADDR - BASE_ADDR;
        addr_err = (PADDR[2:0] != 3'd0) || (PADDR < BASE_ADDR) || ((offset >> 3) >= DEPTH_W);
        addr_idx = offset[AW+2:3];
    end

    // The request being serviced: live bus fields in IDLE (zero-wait case), latched fields otherwise.
    always_comb begin
        req_idx   = idx_q;
        req_write = write_q;
        req_err   = err_q;
        req_data  = data_q;
        if (state == ST_IDLE) begin
            req_idx   = addr_idx;
            req_write = HWRITE;
            req_err   = addr_err;
            req_data  = PDATA;
        end
        enter_resp = ((state == ST_IDLE) && HTRANS && (WAIT_STATES == 0)) ||
                     ((state == ST_WAIT) && (cnt == 8'd1));
    end

    // Request FSM, wait counter, registered response outputs and the word array.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            // NOTE: the array is deliberately absent from this branch: its
            // contents survive reset, and holding reset blocks any pending write.
            state   <= ST_IDLE;
            cnt     <= 8'd0;
            idx_q   <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= 64'd0;
            HRDATA  <= 64'd0;
            HREADY  <= 1'b0;
            HRESP   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register sees pre-edge values regardless of statement order.
            HRDATA <= 64'd0;
            HREADY <= 1'b0;
            HRESP  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (HTRANS) begin
                        idx_q   <= addr_idx;
                        write_q <= HWRITE;
                        err_q   <= addr_err;
                        data_q  <= PDATA;
                        cnt     <= WS_LOAD;
                        state   <= (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - 8'd1;
                    if (cnt == 8'd1) begin
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            if (enter_resp) begin
                HREADY <= 1'b1;
                HRESP  <= req_err;
                if (!req_err) begin
                    if (req_write) begin
                        mem[req_idx] <= req_data;
                    end else begin
                        HRDATA <= mem[req_idx];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder. Three instances cover WAIT_STATES
// 2, 0 and 3 (the last with BASE_ADDR=0x1000). A word-array model with
// "known" flags supplies expected read data; legality comes from the
// address rules written as plain arithmetic.
module tb_mem_responder;

    localparam int DEPTH = 16;
    localparam int NI    = 3;

    logic        HCLK   = 1'b0;
    logic        HRESET = 1'b1;
    logic        htrans [NI];
    logic        hwrite [NI];
    logic [63:0] paddr  [NI];
    logic [63:0] pdata  [NI];
    logic [63:0] hrdata [NI];
    logic        hready [NI];
    logic        hresp  [NI];

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] model_mem [NI][DEPTH];
    bit          known     [NI][DEPTH];
    bit          in_resp   [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        mem_responder #(
            .DEPTH      (DEPTH),
            .WAIT_STATES(g == 0 ? 2 : (g == 1 ? 0 : 3)),
            .BASE_ADDR  (g == 2 ? 64'h1000 : 64'h0)
        ) u_dut (
            .HCLK  (HCLK),
            .HRESET(HRESET),
            .HTRANS(htrans[g]),
            .PADDR (paddr[g]),
            .HWRITE(hwrite[g]),
            .PDATA (pdata[g]),
            .HRDATA(hrdata[g]),
            .HREADY(hready[g]),
            .HRESP (hresp[g])
        );
    end

    always #5 HCLK = ~HCLK;

    function automatic int ws_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 0 : 3);
    endfunction

    function automatic logic [63:0] base_of(input int k);
        return (k == 2) ? 64'h1000 : 64'h0;
    endfunction

    // Legal = word aligned and inside [base, base + 8*DEPTH).
    function automatic bit legal(input int k, input logic [63:0] a);
        logic [63:0] b;
        b = base_of(k);
        if (a % 64'd8 != 64'd0) return 1'b0;
        if (a < b) return 1'b0;
        if (a - b >= 64'(8 * DEPTH)) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drop HTRANS and let at least n cycles pass.
    task automatic idle(input int n);
        for (int k = 0; k < NI; k++) htrans[k] = 1'b0;
        repeat (n) @(negedge HCLK);
        for (int k = 0; k < NI; k++) in_resp[k] = 1'b0;
    endtask

    // One request on instance k. Called at a negedge; returns at the negedge
    // where HREADY is observed high. hold: keep HTRANS/fields until HREADY
    // (else drop and scramble them right after the accept edge). keep: leave
    // HTRANS high on return so the next call is back-to-back.
    task automatic do_req(input int k, input logic [63:0] a, input bit wr,
                          input logic [63:0] d, input bit hold, input bit keep,
                          input string tag);
        bit ok;
        int w;
        int lat;
        ok = legal(k, a);
        w  = ok ? int'((a - base_of(k)) / 64'd8) : 0;
        htrans[k] = 1'b1;
        paddr[k]  = a;
        hwrite[k] = wr;
        pdata[k]  = d;
        if (in_resp[k]) begin
            @(posedge HCLK);
            @(negedge HCLK);
            check({tag, "/gap"}, 64'(hready[k]), 64'd0);
        end
        @(posedge HCLK);
        #1;
        if (!hold) begin
            htrans[k] = 1'b0;
            paddr[k]  = {$urandom, $urandom};
            hwrite[k] = ~wr;
            pdata[k]  = {$urandom, $urandom};
        end
        lat = 0;
        do begin
            @(negedge HCLK);
            lat++;
        end while (hready[k] !== 1'b1 && lat < 300);
        check({tag, "/lat"}, 64'(lat), 64'(ws_of(k) + 1));
        if (lat < 300) begin
            check({tag, "/resp"}, 64'(hresp[k]), 64'(!ok));
            if (!ok || wr) check({tag, "/rdata0"}, hrdata[k], 64'd0);
            else if (known[k][w]) check({tag, "/rdata"}, hrdata[k], model_mem[k][w]);
            in_resp[k] = 1'b1;
        end else begin
            in_resp[k] = 1'b0;
        end
        if (ok && wr) begin
            model_mem[k][w] = d;
            known[k][w]     = 1'b1;
        end
        if (!keep) htrans[k] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: sim time %0t exceeded limit", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        longint      t1;
        int          pulses;
        logic [63:0] a;
        int          cls;

        for (int k = 0; k < NI; k++) begin
            htrans[k]  = 1'b0;
            hwrite[k]  = 1'b0;
            paddr[k]   = 64'd0;
            pdata[k]   = 64'd0;
            in_resp[k] = 1'b0;
        end

        // Reset state of every instance.
        HRESET = 1'b1;
        repeat (3) @(negedge HCLK);
        for (int k = 0; k < NI; k++) begin
            check("rst_hready", 64'(hready[k]), 64'd0);
            check("rst_hresp",  64'(hresp[k]),  64'd0);
            check("rst_hrdata", hrdata[k],      64'd0);
        end
        HRESET = 1'b0;
        idle(2);

        // Write then read with two wait states.
        do_req(0, 64'h18, 1'b1, 64'hDEAD_BEEF_0123_4567, 1'b1, 1'b0, "t2_wr");
        do_req(0, 64'h18, 1'b0, 64'd0, 1'b1, 1'b0, "t2_rd");
        check("t2_rd_value", hrdata[0], 64'hDEAD_BEEF_0123_4567);

        // Reset clears a live response at once.
        do_req(0, 64'h10, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0, "t1_wr_a");
        do_req(0, 64'h10, 1'b0, 64'd0, 1'b1, 1'b0, "t1_rd_a");
        HRESET = 1'b1;
        #1;
        check("t1_rst_resp_hready", 64'(hready[0]), 64'd0);
        check("t1_rst_resp_hrdata", hrdata[0], 64'd0);
        @(negedge HCLK);
        HRESET = 1'b0;
        idle(1);

        // Reset in WAIT drops the write.
        htrans[0] = 1'b1;
        paddr[0]  = 64'h10;
        hwrite[0] = 1'b1;
        pdata[0]  = 64'hFFFF_0000_FFFF_0000;
        @(posedge HCLK);
        @(negedge HCLK);
        HRESET = 1'b1;
        #1;
        check("t1_rst_wait_hready", 64'(hready[0]), 64'd0);
        check("t1_rst_wait_hrdata", hrdata[0], 64'd0);
        @(negedge HCLK);
        HRESET    = 1'b0;
        htrans[0] = 1'b0;
        idle(2);
        do_req(0, 64'h10, 1'b0, 64'd0, 1'b1, 1'b0, "t1_rd_after");
        check("t1_not_dropped_data", hrdata[0], 64'h0123_4567_89AB_CDEF);
        idle(1);

        // Zero wait states: back-to-back reads with HTRANS held.
        do_req(1, 64'h0, 1'b1, 64'h1111_2222_3333_4444, 1'b1, 1'b0, "t3_wr0");
        do_req(1, 64'h8, 1'b1, 64'h5555_6666_7777_8888, 1'b1, 1'b0, "t3_wr8");
        idle(1);
        do_req(1, 64'h0, 1'b0, 64'd0, 1'b1, 1'b1, "t3_rd0");
        t1 = $time;
        do_req(1, 64'h8, 1'b0, 64'd0, 1'b1, 1'b0, "t3_rd8");
        check("t3_spacing", 64'(($time - t1) / 10), 64'd2);
        check("t3_rd8_value", hrdata[1], 64'h5555_6666_7777_8888);
        idle(1);

        // Error cases.
        do_req(0, 64'h0, 1'b1, 64'h0BAD_F00D_0000_0001, 1'b1, 1'b0, "t4_wr0");
        do_req(0, 64'h0C, 1'b0, 64'd0, 1'b1, 1'b0, "t4_misaligned");
        check("t4_mis_hresp", 64'(hresp[0]), 64'd1);
        do_req(0, 64'(8 * DEPTH), 1'b1, 64'hAA, 1'b1, 1'b0, "t4_oob_wr");
        check("t4_oob_hresp", 64'(hresp[0]), 64'd1);
        do_req(0, 64'h0, 1'b0, 64'd0, 1'b1, 1'b0, "t4_rd0");
        check("t4_mem0_unchanged", hrdata[0], 64'h0BAD_F00D_0000_0001);
        idle(1);

        // Boundaries with BASE_ADDR = 0x1000.
        do_req(2, 64'h0FF8, 1'b0, 64'd0, 1'b1, 1'b0, "t5_below_base");
        check("t5_below_hresp", 64'(hresp[2]), 64'd1);
        do_req(2, 64'h1078, 1'b1, 64'hCAFE_0000_0000_BABE, 1'b1, 1'b0, "t5_last_wr");
        do_req(2, 64'h1078, 1'b0, 64'd0, 1'b1, 1'b0, "t5_last_rd");
        check("t5_last_value", hrdata[2], 64'hCAFE_0000_0000_BABE);
        do_req(2, 64'h1080, 1'b0, 64'd0, 1'b1, 1'b0, "t5_past_end");
        check("t5_past_hresp", 64'(hresp[2]), 64'd1);
        idle(1);

        // HTRANS pulsed for the accept cycle only.
        do_req(0, 64'h20, 1'b1, 64'h55, 1'b0, 1'b0, "t6_wr");
        pulses = 0;
        repeat (10) begin
            @(negedge HCLK);
            if (hready[0] === 1'b1) pulses++;
        end
        check("t6_extra_pulses", 64'(pulses), 64'd0);
        in_resp[0] = 1'b0;
        do_req(0, 64'h20, 1'b0, 64'd0, 1'b1, 1'b0, "t6_rd");
        check("t6_value", hrdata[0], 64'h55);
        idle(1);

        // Randomized traffic against the model.
        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < 40; i++) begin
                cls = int'($urandom_range(0, 5));
                case (cls)
                    0, 1:    a = base_of(k) + 64'(8 * $urandom_range(0, DEPTH - 1));
                    2:       a = base_of(k) + 64'(8 * $urandom_range(0, DEPTH - 1)) + 64'($urandom_range(1, 7));
                    3:       a = base_of(k) - 64'(8 * $urandom_range(1, 4));
                    4:       a = base_of(k) + 64'(8 * (DEPTH - 1 + int'($urandom_range(0, 1))));
                    default: a = {$urandom, $urandom};
                endcase
                do_req(k, a, 1'($urandom_range(0, 1)), {$urandom, $urandom},
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
            end
            idle(2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
